reg_ctrl_seq: RTL

//  Multi-cycle control sequencer that sits directly upstream of the general

---
 rtl/reg_ctrl_pkg.sv | 52 +++++
 rtl/reg_ctrl_seq_if.sv | 42 ++++
 rtl/onehot_dec.sv | 22 ++
 rtl/reg_ctrl_seq.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/reg_ctrl_pkg.sv
// Shared definitions for the register-file control sequencer:
// opcode and file-input-mux encodings, FSM state enum, instruction field
// positions and small field-extraction helpers.
package reg_ctrl_pkg;

  // Instruction word layout: [15:13] opcode, [12:8] rx, [7:3] ry, [2:0] unused
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned FIELD_W = 5;
  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 13;
  localparam int unsigned RX_MSB  = 12;
  localparam int unsigned RX_LSB  = 8;
  localparam int unsigned RY_MSB  = 7;
  localparam int unsigned RY_LSB  = 3;
  localparam int unsigned SRC_W   = 2;

  // Opcodes; every other encoding executes as a NOP
  localparam logic [OP_W-1:0] OP_MV  = 3'b000;
  localparam logic [OP_W-1:0] OP_MVI = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB = 3'b011;

  // Register-file input mux selections
  localparam logic [SRC_W-1:0] SRC_OUT2 = 2'b00;
  localparam logic [SRC_W-1:0] SRC_IMM  = 2'b01;
  localparam logic [SRC_W-1:0] SRC_ALU  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    S_MV,
    S_IMM,
    S_WRI,
    S_A,
    S_G,
    S_WB,
    S_NOP
  } state_t;

  function automatic logic [OP_W-1:0] instr_op(input logic [INSTR_W-1:0] ins);
    return ins[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [FIELD_W-1:0] instr_rx(input logic [INSTR_W-1:0] ins);
    return ins[RX_MSB:RX_LSB];
  endfunction

  function automatic logic [FIELD_W-1:0] instr_ry(input logic [INSTR_W-1:0] ins);
    return ins[RY_MSB:RY_LSB];
  endfunction

endpackage

// File: rtl/reg_ctrl_seq_if.sv
// Instruction/immediate handshake plus register-file control lines between
// the instruction source (master) and the sequencer (slave).
//   instr/instr_vld/ready : instruction handshake
//   imm/imm_vld           : immediate word for MVI
//   select/select2        : one-hot write/out-bus and out2 read selects
//   is_in/in_src/imm_q    : file write enable, input mux, latched immediate
//   alu_a_ld/alu_g_ld/alu_sub/done : ALU strobes and completion pulse
interface reg_ctrl_seq_if
  import reg_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SIZE  = 32
);

  logic [INSTR_W-1:0] instr;
  logic               instr_vld;
  logic [WIDTH-1:0]   imm;
  logic               imm_vld;
  logic               ready;
  logic [SIZE-1:0]    select;
  logic [SIZE-1:0]    select2;
  logic               is_in;
  logic [SRC_W-1:0]   in_src;
  logic [WIDTH-1:0]   imm_q;
  logic               alu_a_ld;
  logic               alu_g_ld;
  logic               alu_sub;
  logic               done;

  modport master (
    output instr, instr_vld, imm, imm_vld,
    input  ready, select, select2, is_in, in_src, imm_q,
           alu_a_ld, alu_g_ld, alu_sub, done
  );

  modport slave (
    input  instr, instr_vld, imm, imm_vld,
    output ready, select, select2, is_in, in_src, imm_q,
           alu_a_ld, alu_g_ld, alu_sub, done
  );

endinterface

// File: rtl/onehot_dec.sv
// Register index to one-hot select decoder.
//   idx  : register index
//   oh_c : one-hot vector, all zero when idx >= SIZE
module onehot_dec #(
  parameter int unsigned IDX_W = 5,
  parameter int unsigned SIZE  = 32
) (
  input  logic [IDX_W-1:0] idx,
  output logic [SIZE-1:0]  oh_c
);

  // Out-of-range indices simply match no bit position
  always_comb begin
    oh_c = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (idx == IDX_W'(i)) begin
        oh_c[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_ctrl_seq.sv
// Multi-cycle control sequencer in front of the general register file.
// Accepts one MV/MVI/ADD/SUB/NOP instruction at a time and sequences the
// file selects, write enable, input mux and ALU latch strobes.
//   clk   : clock, rising edge
//   reset : synchronous active-low reset
//   bus   : instruction/immediate handshake and file control (slave side)
module reg_ctrl_seq
  import reg_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SIZE  = 32,
  parameter int unsigned IDX_W = 5
) (
  input logic           clk,
  input logic           reset,
  reg_ctrl_seq_if.slave bus
);

  state_t             state;
  logic [INSTR_W-1:0] instr_q;

  logic [INSTR_W-1:0] cur_instr_c;
  logic [OP_W-1:0]    cur_op_c;
  logic [IDX_W-1:0]   rx_idx_c;
  logic [IDX_W-1:0]   ry_idx_c;
  logic [IDX_W-1:0]   sel2_idx_c;
  logic [SIZE-1:0]    rx_oh_c;
  logic [SIZE-1:0]    sel2_oh_c;
  logic               unused_lsbs;

  // Outputs are registered, so decode the instruction that the *next* state
  // will use: the incoming word while idle, the latched word otherwise.
  always_comb begin
    cur_instr_c = (state == IDLE) ? bus.instr : instr_q;
    cur_op_c    = instr_op(cur_instr_c);
    rx_idx_c    = IDX_W'(instr_rx(cur_instr_c));
    ry_idx_c    = IDX_W'(instr_ry(cur_instr_c));
    // out2 reads rx only when entering S_A; ry for S_MV and S_G
    sel2_idx_c  = ry_idx_c;
    if ((state == IDLE) && ((cur_op_c == OP_ADD) || (cur_op_c == OP_SUB))) begin
      sel2_idx_c = rx_idx_c;
    end
  end

  assign unused_lsbs = ^cur_instr_c[RY_LSB-1:0];

  onehot_dec #(.IDX_W(IDX_W), .SIZE(SIZE)) u_dec_sel (
    .idx  (rx_idx_c),
    .oh_c (rx_oh_c)
  );

  onehot_dec #(.IDX_W(IDX_W), .SIZE(SIZE)) u_dec_sel2 (
    .idx  (sel2_idx_c),
    .oh_c (sel2_oh_c)
  );

  // Sequencer FSM; each branch loads the outputs belonging to the next state
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      instr_q      <= '0;
      bus.imm_q    <= '0;
      bus.ready    <= 1'b1;
      bus.select   <= '0;
      bus.select2  <= '0;
      bus.is_in    <= 1'b0;
      bus.in_src   <= SRC_OUT2;
      bus.alu_a_ld <= 1'b0;
      bus.alu_g_ld <= 1'b0;
      bus.alu_sub  <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.ready    <= 1'b0;
      bus.select   <= '0;
      bus.select2  <= '0;
      bus.is_in    <= 1'b0;
      bus.in_src   <= SRC_OUT2;
      bus.alu_a_ld <= 1'b0;
      bus.alu_g_ld <= 1'b0;
      bus.alu_sub  <= 1'b0;
      bus.done     <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.instr_vld) begin
            instr_q <= bus.instr;
            case (cur_op_c)
              OP_MV: begin
                state       <= S_MV;
                bus.select  <= rx_oh_c;
                bus.select2 <= sel2_oh_c;
                bus.is_in   <= 1'b1;
                bus.in_src  <= SRC_OUT2;
                bus.done    <= 1'b1;
              end
              OP_MVI: begin
                state <= S_IMM;
              end
              OP_ADD, OP_SUB: begin
                state        <= S_A;
                bus.select2  <= sel2_oh_c;
                bus.alu_a_ld <= 1'b1;
                bus.alu_sub  <= cur_op_c[0];
              end
              default: begin
                state    <= S_NOP;
                bus.done <= 1'b1;
              end
            endcase
          end else begin
            bus.ready <= 1'b1;
          end
        end

        // Wait indefinitely for the immediate, all outputs quiet
        S_IMM: begin
          if (bus.imm_vld) begin
            state      <= S_WRI;
            bus.imm_q  <= bus.imm;
            bus.select <= rx_oh_c;
            bus.is_in  <= 1'b1;
            bus.in_src <= SRC_IMM;
            bus.done   <= 1'b1;
          end
        end

        S_A: begin
          state        <= S_G;
          bus.select2  <= sel2_oh_c;
          bus.alu_g_ld <= 1'b1;
          bus.alu_sub  <= cur_op_c[0];
        end

        S_G: begin
          state       <= S_WB;
          bus.select  <= rx_oh_c;
          bus.is_in   <= 1'b1;
          bus.in_src  <= SRC_ALU;
          bus.alu_sub <= cur_op_c[0];
          bus.done    <= 1'b1;
        end

        // S_MV, S_WRI, S_WB, S_NOP: final cycle, return to idle
        default: begin
          state     <= IDLE;
          bus.ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
